// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns pipeline load/store strobes into a req/gnt/rvalid bus access,
// holding the pipeline via stall and returning lane-aligned, extended load data.
module load_store_unit #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [2:0]         funct3,
  input  logic [NBITS-1:0]   mem_addr,
  input  logic [NBITS-1:0]   st_data,
  output logic [NBITS-1:0]   mem_data,
  output logic               stall,
  output logic               lsu_err,
  output logic               bus_req,
  output logic               bus_we,
  output logic [NBITS-1:0]   bus_addr,
  output logic [NBITS/8-1:0] bus_be,
  output logic [NBITS-1:0]   bus_wdata,
  input  logic               bus_gnt,
  input  logic               bus_rvalid,
  input  logic [NBITS-1:0]   bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_e;

  state_e             state_q;
  logic [NBITS-1:0]   mem_data_q;
  logic               lsu_err_q;
  logic               bus_req_q;
  logic               bus_we_q;
  logic [NBITS-1:0]   bus_addr_q;
  logic [NBITS/8-1:0] bus_be_q;
  logic [NBITS-1:0]   bus_wdata_q;
  logic [2:0]         funct3_q;
  logic [1:0]         addr_lo_q;

  logic               err_d;
  logic               start_d;
  logic [NBITS/8-1:0] be_d;
  logic [NBITS-1:0]   wdata_d;
  logic [NBITS-1:0]   load_d;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    err_d   = 1'b0;
    start_d = 1'b0;
    be_d    = 4'b1111;
    wdata_d = st_data;
    if (mem_rd || mem_wr) begin
      err_d = (mem_rd && mem_wr)
           || (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
           || (funct3[1:0] == 2'b01 && mem_addr[0])
           || (funct3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00)
           || (mem_wr && funct3[2]);
    end
    start_d = (mem_rd ^ mem_wr) && !err_d;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << mem_addr[1:0];
        wdata_d = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_d    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the address/size latched at request time, not the live pipeline inputs.
  always_comb begin
    lane_b = bus_rdata[{addr_lo_q, 3'b000} +: 8];
    lane_h = bus_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_d = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_d = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_d = {24'h0, lane_b};
      3'b101:  load_d = {16'h0, lane_h};
      default: load_d = bus_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_data_q  <= '0;
      lsu_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
    end else begin
      lsu_err_q <= (state_q == S_IDLE) && err_d;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q     <= S_REQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_wr;
            bus_addr_q  <= {mem_addr[NBITS-1:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            funct3_q    <= funct3;
            addr_lo_q   <= mem_addr[1:0];
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            bus_req_q <= 1'b0;
            state_q   <= bus_we_q ? S_DONE : S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (bus_rvalid) begin
            mem_data_q <= load_d;
            state_q    <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A legal access stalls in the IDLE cycle it is seen; DONE releases the pipeline.
  assign stall     = (state_q == S_IDLE) ? start_d : (state_q != S_DONE);
  assign mem_data  = mem_data_q;
  assign lsu_err   = lsu_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small bus responder drives gnt/rvalid on request,
// and each scenario task compares the observed bus activity and results to hand-computed values.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] mem_addr, st_data;
  logic [31:0] mem_data;
  logic        stall, lsu_err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations recorded by run_access.
  int          obs_stall, obs_req, obs_err, obs_tail_req, obs_tail_stall;
  bit          obs_stable, obs_timeout;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  load_store_unit #(.NBITS(32)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .mem_addr(mem_addr), .st_data(st_data), .mem_data(mem_data), .stall(stall),
    .lsu_err(lsu_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // Presents one access at a negedge, answers the bus with gnt on the (gnt_wait+1)-th REQ cycle
  // and rvalid rv_wait cycles later, then idles the pipeline for three cycles.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input int gnt_wait, input int rv_wait);
    int  req_idx, gnt_cyc, c;
    bit  done;
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; funct3 = f3; mem_addr = addr; st_data = data;
    obs_stall = 0; obs_req = 0; obs_err = 0; obs_stable = 1; obs_timeout = 0;
    obs_tail_req = 0; obs_tail_stall = 0;
    req_idx = 0; gnt_cyc = -1; c = 0; done = 0;
    while (!done) begin
      #1;
      if (lsu_err) obs_err++;
      if (stall) obs_stall++;
      else done = 1;
      if (bus_req) begin
        if (obs_req == 0) begin
          cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata; cap_we = bus_we;
        end else if (bus_addr !== cap_addr || bus_be !== cap_be ||
                     bus_wdata !== cap_wdata || bus_we !== cap_we) begin
          obs_stable = 0;
        end
        obs_req++;
        if (req_idx == gnt_wait) begin
          bus_gnt = 1'b1;
          gnt_cyc = c;
        end
        req_idx++;
      end
      if (gnt_cyc >= 0 && rv_wait > 0 && c == gnt_cyc + rv_wait) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
      end
      c++;
      if (c >= 50) begin
        obs_timeout = 1;
        done = 1;
      end
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (lsu_err) obs_err++;
      if (bus_req) obs_tail_req++;
      if (stall) obs_tail_stall++;
      @(negedge clk);
    end
    n_cmp++;
    if (obs_timeout) begin
      n_bad++;
      $display("FAIL access_timeout: stall never dropped (f3=%b addr=%h)", f3, addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rd = 0; mem_wr = 0; funct3 = 0; mem_addr = 0; st_data = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mem_data, stall, lsu_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got md=%h st=%b err=%b req=%b we=%b a=%h be=%b wd=%h want all 0",
               mem_data, stall, lsu_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    n_cmp++;
    if (obs_stall !== 2) begin n_bad++; $display("FAIL sw_stall_cycles: got %0d want 2", obs_stall); end
    n_cmp++;
    if (cap_be !== 4'b1111 || cap_addr !== 32'h100 || cap_wdata !== 32'hDEAD_BEEF || cap_we !== 1'b1) begin
      n_bad++;
      $display("FAIL sw_bus: got be=%b a=%h wd=%h we=%b want 1111 100 deadbeef 1", cap_be, cap_addr, cap_wdata, cap_we);
    end
    n_cmp++;
    if (obs_req !== 1 || obs_tail_req !== 0 || obs_tail_stall !== 0) begin
      n_bad++;
      $display("FAIL sw_req_cycles: got req=%0d tail_req=%0d tail_stall=%0d want 1 0 0", obs_req, obs_tail_req, obs_tail_stall);
    end
  endtask

  task automatic test_store_sub_word();
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);
    n_cmp++;
    if (cap_be !== 4'b1000 || cap_wdata !== 32'hA5A5_A5A5 || cap_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL sb_bus: got be=%b wd=%h a=%h want 1000 a5a5a5a5 100", cap_be, cap_wdata, cap_addr);
    end
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0, 1, 0);
    n_cmp++;
    if (cap_be !== 4'b1100 || cap_wdata !== 32'hBEEF_BEEF || cap_addr !== 32'h200 || obs_stall !== 3) begin
      n_bad++;
      $display("FAIL sh_bus: got be=%b wd=%h a=%h stall=%0d want 1100 beefbeef 200 3", cap_be, cap_wdata, cap_addr, obs_stall);
    end
  endtask

  task automatic test_load_extend();
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0202, 32'h0, 32'h12F4_5678, 0, 1);
    n_cmp++;
    if (mem_data !== 32'hFFFF_FFF4 || obs_stall !== 3 || cap_we !== 1'b0 || cap_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL lb: got md=%h stall=%0d we=%b a=%h want fffffff4 3 0 200", mem_data, obs_stall, cap_we, cap_addr);
    end
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_0202, 32'h0, 32'h12F4_5678, 0, 1);
    n_cmp++;
    if (mem_data !== 32'h0000_00F4) begin n_bad++; $display("FAIL lbu: got %h want 000000f4", mem_data); end
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h12F4_5678, 0, 1);
    n_cmp++;
    if (mem_data !== 32'h0000_12F4) begin n_bad++; $display("FAIL lh_hi: got %h want 000012f4", mem_data); end
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0, 32'h1234_8001, 0, 1);
    n_cmp++;
    if (mem_data !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_lo: got %h want ffff8001", mem_data); end
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0, 32'h1234_8001, 0, 1);
    n_cmp++;
    if (mem_data !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu: got %h want 00008001", mem_data); end
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0, 32'h12F4_5678, 0, 1);
    n_cmp++;
    if (mem_data !== 32'h0000_0056) begin n_bad++; $display("FAIL lb_lane1: got %h want 00000056", mem_data); end
  endtask

  task automatic test_illegal();
    logic [31:0] held;
    held = mem_data;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0, 32'h0, 0, 1);
    n_cmp++;
    if (obs_err !== 1 || obs_req !== 0 || obs_tail_req !== 0 || obs_stall !== 0 || mem_data !== held) begin
      n_bad++;
      $display("FAIL lw_misaligned: got err=%0d req=%0d stall=%0d md=%h want 1 0 0 %h",
               obs_err, obs_req + obs_tail_req, obs_stall, mem_data, held);
    end
    run_access(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 0, 1);
    n_cmp++;
    if (obs_err !== 1 || obs_req + obs_tail_req !== 0 || obs_stall !== 0) begin
      n_bad++;
      $display("FAIL rd_and_wr: got err=%0d req=%0d stall=%0d want 1 0 0", obs_err, obs_req + obs_tail_req, obs_stall);
    end
    run_access(1'b0, 1'b1, 3'b100, 32'h0000_0300, 32'h0, 32'h0, 0, 0);
    n_cmp++;
    if (obs_err !== 1 || obs_req + obs_tail_req !== 0) begin
      n_bad++;
      $display("FAIL store_unsigned: got err=%0d req=%0d want 1 0", obs_err, obs_req + obs_tail_req);
    end
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0303, 32'h0, 32'h0, 0, 1);
    n_cmp++;
    if (obs_err !== 1 || obs_req + obs_tail_req !== 0) begin
      n_bad++;
      $display("FAIL lh_odd: got err=%0d req=%0d want 1 0", obs_err, obs_req + obs_tail_req);
    end
    run_access(1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'h0, 32'h0, 0, 1);
    n_cmp++;
    if (obs_err !== 1 || obs_req + obs_tail_req !== 0 || mem_data !== held) begin
      n_bad++;
      $display("FAIL f3_011: got err=%0d req=%0d md=%h want 1 0 %h", obs_err, obs_req + obs_tail_req, mem_data, held);
    end
  endtask

  // gnt arrives on the third REQ cycle, rvalid two cycles after gnt: 1 IDLE + 3 REQ + 2 WAIT_R.
  task automatic test_slow_bus();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'h89AB_CDEF, 2, 2);
    n_cmp++;
    if (obs_stall !== 6 || obs_tail_stall !== 0) begin
      n_bad++;
      $display("FAIL slow_stall: got %0d tail=%0d want 6 0", obs_stall, obs_tail_stall);
    end
    n_cmp++;
    if (!obs_stable || obs_req !== 3 || cap_addr !== 32'h304) begin
      n_bad++;
      $display("FAIL slow_req_stable: got stable=%0d req=%0d a=%h want 1 3 304", obs_stable, obs_req, cap_addr);
    end
    n_cmp++;
    if (mem_data !== 32'h89AB_CDEF) begin n_bad++; $display("FAIL slow_lw_data: got %h want 89abcdef", mem_data); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    mem_rd = 1'b1; funct3 = 3'b010; mem_addr = 32'h0000_0400;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rd = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || mem_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_abort: got st=%b req=%b md=%h want 0 0 0", stall, bus_req, mem_data);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_BABE;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || mem_data !== 32'h0) begin
      n_bad++;
      $display("FAIL late_rvalid: got st=%b req=%b md=%h want 0 0 0", stall, bus_req, mem_data);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_sub_word();
    test_load_extend();
    test_illegal();
    test_slow_bus();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
